// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - request/response/memory bundle for dmem_arbiter
//
// Groups the two requester ports (rq0/rq1), the two response channels
// (rs0/rs1) and the data-memory port into one bundle.
//   slave  : the arbiter's view. It takes requests, returns responses and
//            drives the memory controls.
//   master : the environment's view. This covers the requesters, the
//            response consumers and the data memory.
interface dmem_arbiter_if;
  logic        rq0_valid, rq0_ready, rq0_read, rq0_write, rq0_sext;
  logic [31:0] rq0_addr, rq0_wdata;
  logic [1:0]  rq0_mask;
  logic        rq1_valid, rq1_ready, rq1_read, rq1_write, rq1_sext;
  logic [31:0] rq1_addr, rq1_wdata;
  logic [1:0]  rq1_mask;

  logic        rs0_valid, rs0_ready, rs0_err;
  logic [31:0] rs0_rdata;
  logic        rs1_valid, rs1_ready, rs1_err;
  logic [31:0] rs1_rdata;

  logic        mem_valid, mem_memRead, mem_memWrite, mem_sext, mem_good;
  logic [31:0] mem_addr, mem_writeData, mem_readData;
  logic [1:0]  mem_maskMode;

  modport slave (
    input  rq0_valid, rq0_addr, rq0_wdata, rq0_read, rq0_write, rq0_mask, rq0_sext,
    input  rq1_valid, rq1_addr, rq1_wdata, rq1_read, rq1_write, rq1_mask, rq1_sext,
    output rq0_ready, rq1_ready,
    output rs0_valid, rs0_rdata, rs0_err, rs1_valid, rs1_rdata, rs1_err,
    input  rs0_ready, rs1_ready,
    output mem_valid, mem_memRead, mem_memWrite, mem_sext, mem_addr, mem_writeData, mem_maskMode,
    input  mem_good, mem_readData
  );

  modport master (
    output rq0_valid, rq0_addr, rq0_wdata, rq0_read, rq0_write, rq0_mask, rq0_sext,
    output rq1_valid, rq1_addr, rq1_wdata, rq1_read, rq1_write, rq1_mask, rq1_sext,
    input  rq0_ready, rq1_ready,
    input  rs0_valid, rs0_rdata, rs0_err, rs1_valid, rs1_rdata, rs1_err,
    output rs0_ready, rs1_ready,
    input  mem_valid, mem_memRead, mem_memWrite, mem_sext, mem_addr, mem_writeData, mem_maskMode,
    output mem_good, mem_readData
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data-memory arbiter, one request in flight
//
// Shares the single data-memory port between the load/store unit (port 0)
// and a debug/DMA requester (port 1). The flow for each request is:
//   1. IDLE accepts one request.
//   2. The request is checked for legality.
//   3. ISSUE presents it to memory for exactly one cycle.
//   4. RESP holds the response until the owner consumes it.
//
// Ports:
//   clk   : clock.
//   reset : asynchronous, active-high reset.
//   bus   : dmem_arbiter_if.slave. It carries rq0/rq1 requests, rs0/rs1
//           responses and the mem_* data-memory port.
//
// Parameter:
//   STARVE_LIMIT (1..15) : the number of consecutive contested port-0 grants
//                          after which port 1 is forced.
//
// Build option:
//   DMEM_ARB_RR_EN : when defined, contested arbitration alternates
//                    (round-robin) instead of fixed port-0 priority with the
//                    starvation override.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state;
  logic   owner;
  logic   gnt0, gnt1;

`ifdef DMEM_ARB_RR_EN
  logic rr_ptr;                 // 1: port 1 wins the next contested grant
`else
  logic [3:0] starve_cnt;
`endif

  // Ready is asserted only toward the winner, and only in IDLE outside reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE && !reset) begin
      if (bus.rq0_valid && bus.rq1_valid) begin
`ifdef DMEM_ARB_RR_EN
        gnt1 = rr_ptr;
        gnt0 = ~rr_ptr;
`else
        gnt1 = (starve_cnt == 4'(STARVE_LIMIT));
        gnt0 = ~gnt1;
`endif
      end else begin
        gnt0 = bus.rq0_valid;
        gnt1 = bus.rq1_valid;
      end
    end
  end

  assign bus.rq0_ready = gnt0;
  assign bus.rq1_ready = gnt1;

  logic [31:0] sel_addr, sel_wdata, cap_rdata;
  logic        sel_read, sel_write, sel_sext, sel_illegal;
  logic [1:0]  sel_mask;

  assign sel_addr  = gnt1 ? bus.rq1_addr  : bus.rq0_addr;
  assign sel_wdata = gnt1 ? bus.rq1_wdata : bus.rq0_wdata;
  assign sel_read  = gnt1 ? bus.rq1_read  : bus.rq0_read;
  assign sel_write = gnt1 ? bus.rq1_write : bus.rq0_write;
  assign sel_mask  = gnt1 ? bus.rq1_mask  : bus.rq0_mask;
  assign sel_sext  = gnt1 ? bus.rq1_sext  : bus.rq0_sext;

  // A request is illegal when it is ambiguous (neither or both of read and
  // write set), uses the reserved size, or is a misaligned half or word.
  assign sel_illegal = (sel_read == sel_write) || (sel_mask == 2'b11) ||
                       (sel_mask == 2'b01 && sel_addr[0]) ||
                       (sel_mask == 2'b10 && sel_addr[1:0] != 2'b00);

  // Only a successful load returns data.
  assign cap_rdata = (bus.mem_memRead && bus.mem_good) ? bus.mem_readData : 32'h0;

  // The mem_* registers double as the latched copy of the accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      owner             <= 1'b0;
      bus.rs0_valid     <= 1'b0;
      bus.rs0_rdata     <= 32'h0;
      bus.rs0_err       <= 1'b0;
      bus.rs1_valid     <= 1'b0;
      bus.rs1_rdata     <= 32'h0;
      bus.rs1_err       <= 1'b0;
      bus.mem_valid     <= 1'b0;
      bus.mem_addr      <= 32'h0;
      bus.mem_writeData <= 32'h0;
      bus.mem_memRead   <= 1'b0;
      bus.mem_memWrite  <= 1'b0;
      bus.mem_maskMode  <= 2'b00;
      bus.mem_sext      <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      rr_ptr            <= 1'b0;
`else
      starve_cnt        <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            owner <= gnt1;
`ifdef DMEM_ARB_RR_EN
            rr_ptr <= gnt0;
`else
            // Count only port-0 grants taken while port 1 was waiting.
            if (gnt1 || !bus.rq1_valid) starve_cnt <= 4'd0;
            else                        starve_cnt <= starve_cnt + 4'd1;
`endif
            if (sel_illegal) begin
              state <= RESP;
              if (gnt1) begin
                bus.rs1_valid <= 1'b1;
                bus.rs1_rdata <= 32'h0;
                bus.rs1_err   <= 1'b1;
              end else begin
                bus.rs0_valid <= 1'b1;
                bus.rs0_rdata <= 32'h0;
                bus.rs0_err   <= 1'b1;
              end
            end else begin
              state             <= ISSUE;
              bus.mem_valid     <= 1'b1;
              bus.mem_addr      <= sel_addr;
              bus.mem_writeData <= sel_wdata;
              bus.mem_memRead   <= sel_read;
              bus.mem_memWrite  <= sel_write;
              bus.mem_maskMode  <= sel_mask;
              bus.mem_sext      <= sel_sext;
            end
          end
        end
        ISSUE: begin
          state             <= RESP;
          bus.mem_valid     <= 1'b0;
          bus.mem_addr      <= 32'h0;
          bus.mem_writeData <= 32'h0;
          bus.mem_memRead   <= 1'b0;
          bus.mem_memWrite  <= 1'b0;
          bus.mem_maskMode  <= 2'b00;
          bus.mem_sext      <= 1'b0;
          if (owner) begin
            bus.rs1_valid <= 1'b1;
            bus.rs1_rdata <= cap_rdata;
            bus.rs1_err   <= ~bus.mem_good;
          end else begin
            bus.rs0_valid <= 1'b1;
            bus.rs0_rdata <= cap_rdata;
            bus.rs0_err   <= ~bus.mem_good;
          end
        end
        RESP: begin
          if (owner ? bus.rs1_ready : bus.rs0_ready) begin
            state         <= IDLE;
            bus.rs0_valid <= 1'b0;
            bus.rs0_rdata <= 32'h0;
            bus.rs0_err   <= 1'b0;
            bus.rs1_valid <= 1'b0;
            bus.rs1_rdata <= 32'h0;
            bus.rs1_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
